fetch_decode_elastic_buffer: RTL and testbench
==============================================

Name: fetch_decode_elastic_buffer

Overview:
Parametrised successor to the fixed fetch/decode pipeline register. It carries {pc, instr} from fetch to decode through a 2-entry elastic buffer (main + skid) with valid/ready handshakes. Provides back-pressure, synchronous flush and NOP bubble insertion at full throughput. Sits between the fetch stage and the decode stage; the same block is reused wherever the pipeline needs a stallable or flushable stage boundary.

Parameters:
PC_W, 32, width of the program counter payload
INSTR_W, 16, width of the instruction payload
NOP_INSTR, {INSTR_W{1'b0}}, instruction driven on o_instr whenever o_valid=0
RESET_PC, {PC_W{1'b0}}, value of o_pc after reset and after flush

Ports:
i_clk  input  1  clock; all state updates on posedge
i_reset_n  input  1  synchronous reset, active-low
i_flush  input  1  synchronous flush; discards all buffered entries
i_valid  input  1  fetch presents a valid {i_pc, i_instr}
o_ready  output  1  buffer can accept; registered (equals ~skid_valid)
i_pc  input  PC_W  fetched PC
i_instr  input  INSTR_W  fetched instruction
o_valid  output  1  main entry holds a valid instruction for decode
i_ready  input  1  decode consumes the main entry this cycle
o_pc  output  PC_W  PC of the main entry
o_instr  output  INSTR_W  instruction of the main entry, or NOP_INSTR when invalid
o_count  output  2  occupancy: main_valid + skid_valid (0..2)

Behaviour:
- in_fire = i_valid & o_ready; out_fire = o_valid & i_ready. Both are evaluated on the pre-edge state.
- Reset (i_reset_n=0 at posedge): o_valid=0, o_pc=RESET_PC, o_instr=NOP_INSTR, skid empty, o_count=0. o_ready reads 1 (skid empty), but inputs are ignored while reset is low. Reset has priority over flush and over all handshakes.
- Flush (i_flush=1, reset high): next state is main invalid, o_instr=NOP_INSTR, o_pc=RESET_PC, skid empty. A same-cycle in_fire is discarded. A same-cycle out_fire still counts as consumed by decode, and decode must ignore it itself.
- Normal update, main empty or out_fire:
  - skid valid: main <= skid and skid empties. in_fire is impossible because o_ready=0.
  - else in_fire: main <= {i_pc, i_instr}, o_valid <= 1.
  - else: o_valid <= 0, o_instr <= NOP_INSTR, o_pc holds its last value.
- Normal update, main full and not out_fire:
  - in_fire: skid <= {i_pc, i_instr}, and o_ready drops the next cycle.
  - else: everything holds.
- Main and skid never both load from the input in the same cycle.
- Ordering is strict FIFO: the skid entry always precedes any later input.
- Latency is 1 cycle from in_fire to o_valid when empty. Sustained throughput is 1 per cycle with i_ready=1.
- A stall of any length (i_ready=0) holds o_pc/o_instr stable and loses nothing. At most 2 entries are accepted during a stall.
- o_ready depends only on registers. There is no combinational path from i_ready to o_ready.
- o_count is 2 exactly when o_ready=0.

Decomposition:
- Shared pipeline package/include: NOP_INSTR encoding, default PC_W/INSTR_W, RESET_PC. The opcode file defines NOP, so all stage buffers take it from here.
- One natural sub-module: pipe_slot. It is one {valid, pc, instr} register with load, clear and reset-value inputs. It is instantiated twice, as main and skid. Main drives NOP_INSTR when invalid.
- Top-level next-state/select logic stays in fetch_decode_elastic_buffer.

Test Plan:
- Reset: hold i_reset_n=0 for 2 cycles with i_valid=1, i_pc=0x10 -> o_valid=0, o_pc=0, o_instr=0x0000, o_count=0. The first accept happens on the cycle after release.
- Streaming: i_ready=1, send pc 0x100..0x10F with one instr per cycle -> each pair appears on o_pc/o_instr exactly 1 cycle later. o_ready stays 1 and o_count stays 1.
- Stall/skid: pc 0x200 and 0x202 accepted, then i_ready=0 for 5 cycles -> o_count=2, o_ready=0, o_pc holds 0x200. After i_ready=1, 0x200 then 0x202 emerge in order with no loss or duplication.
- Flush with full buffer: o_count=2, then assert i_flush with i_valid=1, i_pc=0x300 -> next cycle o_valid=0, o_instr=NOP_INSTR, o_pc=0, o_count=0, o_ready=1, and 0x300 is discarded.
- Bubble: i_valid toggles 1,0,1 with i_ready=1 -> o_valid goes 1,0,1. o_instr is NOP_INSTR in the bubble cycle and o_pc holds its previous value.
- Random valid/ready with random flush, compared against a reference queue model -> order preserved and o_count matches. Also hold reset mid-stall -> every output returns to reset values.

Source files
------------

// File: rtl/fetch_decode_elastic_buffer_pkg.sv
// Shared pipeline constants for stage-boundary buffers: default widths,
// the NOP encoding from the opcode map, and the post-reset PC.
package fetch_decode_elastic_buffer_pkg;

    localparam int DEF_PC_W    = 32;
    localparam int DEF_INSTR_W = 16;

    localparam logic [DEF_INSTR_W-1:0] PKG_NOP_INSTR = '0;
    localparam logic [DEF_PC_W-1:0]    PKG_RESET_PC  = '0;

endpackage

// File: rtl/fetch_decode_elastic_buffer_pipe_slot.sv
// One {valid, pc, instr} holding register. Priority: reset, clear, load, drop.
// A drop empties the slot and parks NOP in instr while pc keeps its last value.
module fetch_decode_elastic_buffer_pipe_slot
    import fetch_decode_elastic_buffer_pkg::*;
#(
    parameter int                 PC_W      = DEF_PC_W,
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic               i_drop,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_valid,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instr
);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            o_valid <= 1'b0;
            o_pc    <= RESET_PC;
            o_instr <= NOP_INSTR;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_pc    <= i_pc;
            o_instr <= i_instr;
        end else if (i_drop) begin
            o_valid <= 1'b0;
            o_instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_decode_elastic_buffer.sv
// Two-entry (main + skid) elastic stage boundary carrying {pc, instr} from
// fetch to decode, with back-pressure, synchronous flush and NOP bubbles.
module fetch_decode_elastic_buffer
    import fetch_decode_elastic_buffer_pkg::*;
#(
    parameter int                 PC_W      = DEF_PC_W,
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PKG_NOP_INSTR),
    parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(PKG_RESET_PC)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic [1:0]         o_count
);

    logic               main_valid;
    logic               skid_valid;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    logic               in_fire;
    logic               out_fire;
    logic               main_adv;
    logic               main_load;
    logic               main_drop;
    logic               skid_load;
    logic               skid_drop;
    logic [PC_W-1:0]    main_pc_nxt;
    logic [INSTR_W-1:0] main_instr_nxt;

    // o_ready comes straight from the skid register, never from i_ready
    assign o_ready  = ~skid_valid;
    assign o_valid  = main_valid;
    assign o_count  = {1'b0, main_valid} + {1'b0, skid_valid};

    assign in_fire  = i_valid & o_ready;
    assign out_fire = main_valid & i_ready;
    assign main_adv = ~main_valid | out_fire;

    always_comb begin
        main_load      = 1'b0;
        main_drop      = 1'b0;
        skid_load      = 1'b0;
        skid_drop      = 1'b0;
        main_pc_nxt    = i_pc;
        main_instr_nxt = i_instr;
        if (main_adv) begin
            if (skid_valid) begin
                // skid is older than anything on the input, so it goes first
                main_load      = 1'b1;
                skid_drop      = 1'b1;
                main_pc_nxt    = skid_pc;
                main_instr_nxt = skid_instr;
            end else if (in_fire) begin
                main_load = 1'b1;
            end else begin
                main_drop = 1'b1;
            end
        end else if (in_fire) begin
            skid_load = 1'b1;
        end
    end

    // main stage: the entry presented to decode
    fetch_decode_elastic_buffer_pipe_slot #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_main (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_flush),
        .i_load    (main_load),
        .i_drop    (main_drop),
        .i_pc      (main_pc_nxt),
        .i_instr   (main_instr_nxt),
        .o_valid   (main_valid),
        .o_pc      (o_pc),
        .o_instr   (o_instr)
    );

    // skid stage: catches the one input accepted while main is stalled
    fetch_decode_elastic_buffer_pipe_slot #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_flush),
        .i_load    (skid_load),
        .i_drop    (skid_drop),
        .i_pc      (i_pc),
        .i_instr   (i_instr),
        .o_valid   (skid_valid),
        .o_pc      (skid_pc),
        .o_instr   (skid_instr)
    );

endmodule

// File: tb/tb_fetch_decode_elastic_buffer.sv
// Bench for fetch_decode_elastic_buffer: queue reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fetch_decode_elastic_buffer;

    localparam int              PC_W    = 32;
    localparam int              INSTR_W = 16;
    localparam logic [15:0]     NOP     = 16'h0000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               out_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               dut_ready;
    logic               dut_valid;
    logic [PC_W-1:0]    dut_pc;
    logic [INSTR_W-1:0] dut_instr;
    logic [1:0]         dut_count;

    always #5 clk = ~clk;

    fetch_decode_elastic_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_flush   (flush),
        .i_valid   (in_valid),
        .o_ready   (dut_ready),
        .i_pc      (in_pc),
        .i_instr   (in_instr),
        .o_valid   (dut_valid),
        .i_ready   (out_ready),
        .o_pc      (dut_pc),
        .o_instr   (dut_instr),
        .o_count   (dut_count)
    );

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    ent_t            q[$];
    logic [PC_W-1:0] last_pc;
    int              checks = 0;
    int              passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: a FIFO of at most 2 entries; decode sees the head.
    task automatic model_edge();
        ent_t e;
        logic in_f;
        logic out_f;
        if (!rst_n || flush) begin
            q.delete();
            last_pc = '0;
        end else begin
            out_f = (q.size() > 0) && out_ready;
            in_f  = in_valid && (q.size() < 2);
            if (out_f) begin
                e = q.pop_front();
                if (q.size() == 0) last_pc = e.pc;
            end
            if (in_f) begin
                e.pc    = in_pc;
                e.instr = in_instr;
                q.push_back(e);
            end
        end
    endtask

    task automatic compare();
        logic [PC_W-1:0]    exp_pc;
        logic [INSTR_W-1:0] exp_instr;
        exp_pc    = (q.size() > 0) ? q[0].pc : last_pc;
        exp_instr = (q.size() > 0) ? q[0].instr : NOP;
        chk("model_valid", 64'(dut_valid), 64'(q.size() > 0));
        chk("model_ready", 64'(dut_ready), 64'(q.size() < 2));
        chk("model_count", 64'(dut_count), 64'(q.size()));
        chk("model_pc",    64'(dut_pc),    64'(exp_pc));
        chk("model_instr", 64'(dut_instr), 64'(exp_instr));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        last_pc   = '0;
        drive(1'b1, 32'h10, 16'h0A10);

        // reset held two cycles with a valid input present
        repeat (2) cycle();
        chk("rst_valid", 64'(dut_valid), 64'd0);
        chk("rst_pc",    64'(dut_pc),    64'd0);
        chk("rst_instr", 64'(dut_instr), 64'h0000);
        chk("rst_count", 64'(dut_count), 64'd0);
        chk("rst_ready", 64'(dut_ready), 64'd1);

        rst_n = 1'b1;
        cycle();
        chk("first_accept_valid", 64'(dut_valid), 64'd1);
        chk("first_accept_pc",    64'(dut_pc),    64'h10);

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 16'h1000 + 16'(i));
            cycle();
            chk("stream_pc",    64'(dut_pc),    64'h100 + 64'(i));
            chk("stream_count", 64'(dut_count), 64'd1);
            chk("stream_ready", 64'(dut_ready), 64'd1);
        end
        drive(1'b0, 32'hDEAD, 16'hBEEF);
        cycle();
        chk("drain_valid", 64'(dut_valid), 64'd0);
        chk("drain_pc",    64'(dut_pc),    64'h10F);

        // stall fills main and skid
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 16'h2200);
        cycle();
        drive(1'b1, 32'h202, 16'h2202);
        cycle();
        chk("stall_count", 64'(dut_count), 64'd2);
        chk("stall_ready", 64'(dut_ready), 64'd0);
        drive(1'b1, 32'h204, 16'h2204);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_hold_pc", 64'(dut_pc), 64'h200);
        end
        drive(1'b0, 32'h0, 16'h0);
        out_ready = 1'b1;
        cycle();
        chk("unstall_pc1",    64'(dut_pc),    64'h202);
        chk("unstall_count1", 64'(dut_count), 64'd1);
        cycle();
        chk("unstall_valid2", 64'(dut_valid), 64'd0);

        // flush with a full buffer and a concurrent input
        out_ready = 1'b0;
        drive(1'b1, 32'h280, 16'h2280);
        cycle();
        drive(1'b1, 32'h282, 16'h2282);
        cycle();
        chk("preflush_count", 64'(dut_count), 64'd2);
        flush = 1'b1;
        drive(1'b1, 32'h300, 16'h3300);
        cycle();
        chk("flush_valid", 64'(dut_valid), 64'd0);
        chk("flush_instr", 64'(dut_instr), 64'h0000);
        chk("flush_pc",    64'(dut_pc),    64'd0);
        chk("flush_count", 64'(dut_count), 64'd0);
        chk("flush_ready", 64'(dut_ready), 64'd1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 16'h0);
        cycle();
        chk("flush_discard", 64'(dut_valid), 64'd0);

        // bubble
        out_ready = 1'b1;
        drive(1'b1, 32'h400, 16'h4400);
        cycle();
        chk("bubble_v1", 64'(dut_valid), 64'd1);
        drive(1'b0, 32'h0, 16'h0);
        cycle();
        chk("bubble_v0",    64'(dut_valid), 64'd0);
        chk("bubble_instr", 64'(dut_instr), 64'h0000);
        chk("bubble_pc",    64'(dut_pc),    64'h400);
        drive(1'b1, 32'h404, 16'h4404);
        cycle();
        chk("bubble_v1b", 64'(dut_valid), 64'd1);
        chk("bubble_pc2", 64'(dut_pc),    64'h404);

        // random traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 32'h1000 + 32'(i), 16'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0;

        // reset in the middle of a stall
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 16'h5500);
        cycle();
        drive(1'b1, 32'h502, 16'h5502);
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("midrst_valid", 64'(dut_valid), 64'd0);
        chk("midrst_pc",    64'(dut_pc),    64'd0);
        chk("midrst_instr", 64'(dut_instr), 64'h0000);
        chk("midrst_count", 64'(dut_count), 64'd0);
        chk("midrst_ready", 64'(dut_ready), 64'd1);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 16'h0);
        cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
